// File: rtl/piano_pkg.sv
// Shared constants and types for the piano polyphony scheduler.
package piano_pkg;
  localparam int NUM_KEYS  = 32;
  localparam int KEY_IDX_W = 5;

  typedef enum logic {
    ST_SNAP = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  // Age counters hold 0..NUM_VOICES-1; keep at least one bit.
  function automatic int age_w(input int nv);
    return (nv <= 2) ? 1 : $clog2(nv);
  endfunction
endpackage

// File: rtl/voice_pick.sv
// Combinational voice lookup: key-already-held hit, lowest free voice, oldest voice.
module voice_pick
  import piano_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 2,
  parameter int VID_W      = 2
) (
  input  logic [NUM_VOICES-1:0]                i_on,
  input  logic [NUM_VOICES-1:0][AGE_W-1:0]     i_age,
  input  logic [NUM_VOICES-1:0][KEY_IDX_W-1:0] i_idx,
  input  logic [KEY_IDX_W-1:0]                 i_k,
  output logic                                 o_hit,
  output logic                                 o_free_found,
  output logic [VID_W-1:0]                     o_free_v,
  output logic [VID_W-1:0]                     o_oldest_v
);
  logic [AGE_W-1:0] w_best;

  always_comb begin
    o_hit        = 1'b0;
    o_free_found = 1'b0;
    o_free_v     = '0;
    o_oldest_v   = '0;
    w_best       = i_age[0];
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (i_on[v] && (i_idx[v] == i_k)) o_hit = 1'b1;
    end
    // Descending walk so the last write is the lowest free index.
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!i_on[v]) begin
        o_free_found = 1'b1;
        o_free_v     = VID_W'(v);
      end
    end
    // Strictly-greater keeps ties on the lowest index.
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (i_age[v] > w_best) begin
        w_best     = i_age[v];
        o_oldest_v = VID_W'(v);
      end
    end
  end
endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: snapshots the key vector, releases voices, then scans
// one key per cycle allocating (or stealing) generator slots.
module voice_allocator
  import piano_pkg::*;
#(
  parameter int NUM_KEYS   = 32,
  parameter int NUM_VOICES = 4,
  parameter int STEAL      = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [31:0]                   key_pressed,
  output logic [5*NUM_VOICES-1:0]       voice_index,
  output logic [NUM_VOICES-1:0]         voice_on,
  output logic [NUM_VOICES-1:0]         voice_retrig,
  output logic                          steal_pulse,
  output logic                          scan_done,
  output logic [3:0]                    active_count
);
  localparam int AGE_W = age_w(NUM_VOICES);
  localparam int VID_W = AGE_W;

  state_e                               r_state, w_state_nxt;
  logic [31:0]                          r_key_q, w_key_q_nxt;
  logic [KEY_IDX_W-1:0]                 r_ptr, w_ptr_nxt;
  logic [NUM_VOICES-1:0]                r_on, w_on_nxt;
  logic [NUM_VOICES-1:0][KEY_IDX_W-1:0] r_idx, w_idx_nxt;
  logic [NUM_VOICES-1:0][AGE_W-1:0]     r_age, w_age_nxt;
  logic [NUM_VOICES-1:0]                r_retrig, w_retrig_nxt;
  logic                                 r_steal, w_steal_nxt;
  logic                                 r_done, w_done_nxt;
  logic [3:0]                           r_cnt, w_cnt_nxt;

  logic                                 w_hit, w_free_found, w_alloc;
  logic [VID_W-1:0]                     w_free_v, w_oldest_v, w_tgt;

  voice_pick #(
    .NUM_VOICES(NUM_VOICES),
    .AGE_W     (AGE_W),
    .VID_W     (VID_W)
  ) u_pick (
    .i_on        (r_on),
    .i_age       (r_age),
    .i_idx       (r_idx),
    .i_k         (r_ptr),
    .o_hit       (w_hit),
    .o_free_found(w_free_found),
    .o_free_v    (w_free_v),
    .o_oldest_v  (w_oldest_v)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_key_q_nxt  = r_key_q;
    w_ptr_nxt    = r_ptr;
    w_on_nxt     = r_on;
    w_idx_nxt    = r_idx;
    w_age_nxt    = r_age;
    w_retrig_nxt = '0;
    w_steal_nxt  = 1'b0;
    w_done_nxt   = 1'b0;
    w_alloc      = 1'b0;
    w_tgt        = '0;
    w_cnt_nxt    = '0;
    case (r_state)
      ST_SNAP: begin
        w_key_q_nxt = key_pressed;
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (r_on[v] && !key_pressed[r_idx[v]]) begin
            w_on_nxt[v]  = 1'b0;
            w_age_nxt[v] = '0;
          end
        end
        w_ptr_nxt   = '0;
        w_state_nxt = ST_SCAN;
      end
      default: begin
        if (r_key_q[r_ptr] && !w_hit) begin
          if (w_free_found) begin
            w_alloc = 1'b1;
            w_tgt   = w_free_v;
          end else if (STEAL != 0) begin
            w_alloc     = 1'b1;
            w_tgt       = w_oldest_v;
            w_steal_nxt = 1'b1;
          end
        end
        if (w_alloc) begin
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (w_tgt == VID_W'(v)) begin
              w_idx_nxt[v]    = r_ptr;
              w_on_nxt[v]     = 1'b1;
              w_retrig_nxt[v] = 1'b1;
              w_age_nxt[v]    = '0;
            end else if (r_on[v] && (r_age[v] < AGE_W'(NUM_VOICES - 1))) begin
              w_age_nxt[v] = r_age[v] + 1'b1;
            end
          end
        end
        w_ptr_nxt = r_ptr + 1'b1;
        if (r_ptr == KEY_IDX_W'(NUM_KEYS - 1)) begin
          w_done_nxt  = 1'b1;
          w_ptr_nxt   = '0;
          w_state_nxt = ST_SNAP;
        end
      end
    endcase
    for (int v = 0; v < NUM_VOICES; v++) w_cnt_nxt = w_cnt_nxt + {3'b000, w_on_nxt[v]};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_SNAP;
      r_key_q  <= '0;
      r_ptr    <= '0;
      r_on     <= '0;
      r_idx    <= '0;
      r_age    <= '0;
      r_retrig <= '0;
      r_steal  <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_key_q  <= w_key_q_nxt;
      r_ptr    <= w_ptr_nxt;
      r_on     <= w_on_nxt;
      r_idx    <= w_idx_nxt;
      r_age    <= w_age_nxt;
      r_retrig <= w_retrig_nxt;
      r_steal  <= w_steal_nxt;
      r_done   <= w_done_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign voice_index  = r_idx;
  assign voice_on     = r_on;
  assign voice_retrig = r_retrig;
  assign steal_pulse  = r_steal;
  assign scan_done    = r_done;
  assign active_count = r_cnt;
endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench: a frame-level model predicts each frame's outcome at SNAP,
// a monitor checks it at scan_done. Instance 0 steals, instance 1 does not.
module tb_voice_allocator;
  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] key_pressed = 32'hFFFF_FFFF;
  logic [19:0] vi0, vi1;
  logic [3:0]  on0, on1, rt0, rt1, ac0, ac1;
  logic        sp0, sp1, sd0, sd1;

  always #10 clk = ~clk;

  voice_allocator #(.NUM_KEYS(32), .NUM_VOICES(4), .STEAL(1)) dut (
    .clk(clk), .resetn(resetn), .key_pressed(key_pressed),
    .voice_index(vi0), .voice_on(on0), .voice_retrig(rt0),
    .steal_pulse(sp0), .scan_done(sd0), .active_count(ac0));

  voice_allocator #(.NUM_KEYS(32), .NUM_VOICES(4), .STEAL(0)) dut_ns (
    .clk(clk), .resetn(resetn), .key_pressed(key_pressed),
    .voice_index(vi1), .voice_on(on1), .voice_retrig(rt1),
    .steal_pulse(sp1), .scan_done(sd1), .active_count(ac1));

  logic [19:0] d_vi [2];
  logic [3:0]  d_on [2], d_rt [2], d_ac [2];
  logic        d_sp [2], d_sd [2];
  assign d_vi[0] = vi0; assign d_vi[1] = vi1;
  assign d_on[0] = on0; assign d_on[1] = on1;
  assign d_rt[0] = rt0; assign d_rt[1] = rt1;
  assign d_ac[0] = ac0; assign d_ac[1] = ac1;
  assign d_sp[0] = sp0; assign d_sp[1] = sp1;
  assign d_sd[0] = sd0; assign d_sd[1] = sd1;

  typedef struct {
    logic [3:0]  on;
    logic [19:0] idx;
    int          act;
    int          steals;
    int          retrigs;
  } exp_t;

  exp_t q0[$], q1[$];
  int   m_on [2][4], m_idx [2][4], m_age [2][4];
  int   m_phase = 0;
  int   compared = 0, mismatched = 0;
  int   acc_s [2], acc_r [2];

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One whole frame from the rules: release against the snapshot, then keys 0..31 in order.
  function automatic exp_t frame(input int i, input logic [31:0] snap);
    exp_t e;
    int   t, best;
    bit   held;
    e.steals = 0; e.retrigs = 0; e.act = 0; e.on = '0; e.idx = '0;
    for (int v = 0; v < 4; v++)
      if (m_on[i][v] != 0 && !snap[m_idx[i][v]]) begin m_on[i][v] = 0; m_age[i][v] = 0; end
    for (int k = 0; k < 32; k++) begin
      if (!snap[k]) continue;
      held = 0;
      for (int v = 0; v < 4; v++) if (m_on[i][v] != 0 && m_idx[i][v] == k) held = 1;
      if (held) continue;
      t = -1;
      for (int v = 3; v >= 0; v--) if (m_on[i][v] == 0) t = v;
      if (t < 0 && i == 0) begin
        best = -1;
        for (int v = 0; v < 4; v++) if (m_age[i][v] > best) begin best = m_age[i][v]; t = v; end
        e.steals++;
      end
      if (t < 0) continue;
      for (int v = 0; v < 4; v++) begin
        if (v == t) begin m_idx[i][v] = k; m_on[i][v] = 1; m_age[i][v] = 0; end
        else if (m_on[i][v] != 0 && m_age[i][v] < 3) m_age[i][v]++;
      end
      e.retrigs++;
    end
    for (int v = 0; v < 4; v++) begin
      e.on[v] = (m_on[i][v] != 0);
      e.idx[5*v +: 5] = 5'(m_idx[i][v]);
      e.act += m_on[i][v];
    end
    return e;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++)
        for (int v = 0; v < 4; v++) begin m_on[i][v] = 0; m_idx[i][v] = 0; m_age[i][v] = 0; end
      q0.delete(); q1.delete();
      m_phase = 0;
    end else begin
      if (m_phase == 0) begin
        q0.push_back(frame(0, key_pressed));
        q1.push_back(frame(1, key_pressed));
      end
      m_phase = (m_phase == 32) ? 0 : m_phase + 1;
    end
  end

  always @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin acc_s[i] = 0; acc_r[i] = 0; end
    end else begin
      for (int i = 0; i < 2; i++) begin
        exp_t e;
        chk($sformatf("retrig_onehot%0d", i), int'($countones(d_rt[i]) <= 1), 1);
        chk($sformatf("active_count%0d", i), int'(d_ac[i]), $countones(d_on[i]));
        chk($sformatf("scan_done_timing%0d", i), int'(d_sd[i]), int'(m_phase == 0));
        acc_s[i] += int'(d_sp[i]);
        acc_r[i] += $countones(d_rt[i]);
        if (d_sd[i]) begin
          if ((i == 0 ? q0.size() : q1.size()) == 0) chk($sformatf("queue_empty%0d", i), 1, 0);
          else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("voice_on%0d", i), int'(d_on[i]), int'(e.on));
            chk($sformatf("voice_index%0d", i), int'(d_vi[i]), int'(e.idx));
            chk($sformatf("frame_active%0d", i), int'(d_ac[i]), e.act);
            chk($sformatf("frame_steals%0d", i), acc_s[i], e.steals);
            chk($sformatf("frame_retrigs%0d", i), acc_r[i], e.retrigs);
          end
          acc_s[i] = 0; acc_r[i] = 0;
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_on%0d", tag, i), int'(d_on[i]), 0);
      chk($sformatf("%s_idx%0d", tag, i), int'(d_vi[i]), 0);
      chk($sformatf("%s_rt%0d", tag, i), int'(d_rt[i]), 0);
      chk($sformatf("%s_sp%0d", tag, i), int'(d_sp[i]), 0);
      chk($sformatf("%s_sd%0d", tag, i), int'(d_sd[i]), 0);
      chk($sformatf("%s_ac%0d", tag, i), int'(d_ac[i]), 0);
    end
  endtask

  task automatic release_reset();
    @(negedge clk); #5 resetn = 1'b1;
  endtask

  initial begin
    logic [31:0] keys;
    int n;
    #2 resetn = 1'b0;
    cycles(3);
    chk_zero("reset");
    key_pressed = '0;
    release_reset();
    cycles(40);

    key_pressed = 32'h0000_0008;
    cycles(70);
    key_pressed = '0;
    cycles(40);

    key_pressed = (1 << 1) | (1 << 5) | (1 << 9) | (1 << 12);
    cycles(70);
    key_pressed = key_pressed | (1 << 20);
    cycles(40);
    key_pressed = (1 << 20) | (1 << 5) | (1 << 9) | (1 << 12);
    cycles(70);
    key_pressed = (1 << 20) | (1 << 2) | (1 << 9) | (1 << 12);
    cycles(70);

    repeat (40) begin
      keys = key_pressed;
      if ($urandom_range(0, 3) == 0) keys = '0;
      n = $urandom_range(0, 5);
      for (int j = 0; j < n; j++) keys[$urandom_range(0, 31)] ^= 1'b1;
      key_pressed = keys;
      cycles($urandom_range(1, 80));
    end

    key_pressed = '0;
    cycles(40);
    key_pressed = (1 << 0) | (1 << 4) | (1 << 7);
    cycles(70);
    n = 0;
    while (n < 40 && m_phase != 11) begin @(negedge clk); n++; end
    chk("align_ptr10", m_phase, 11);
    chk("pre_reset_on", int'(on0), 4'b0111);
    #3 resetn = 1'b0;
    #1 chk_zero("midscan");
    cycles(2);
    release_reset();
    cycles(70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
